// File: rtl/alu_pkg.sv
// Shared opcode and FSM state types for the handshaked sequential ALU.
package alu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_NOT = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SLT = 4'd6,
        OP_EQ  = 4'd7,
        OP_MUL = 4'd8
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles.
// o_done pulses for one cycle after the last step; o_product holds until the next start.
module alu_mul_iter #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_busy,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH:0]     w_sum;

    // Upper half accumulates, lower half holds the remaining multiplier bits.
    assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                 + (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_acc   <= {{WIDTH{1'b0}}, i_b};
                r_mcand <= i_a;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
            end else if (r_busy) begin
                r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == CNT_W'(WIDTH-1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_product = r_acc;

endmodule

// File: rtl/seq_alu.sv
// Handshaked WIDTH-bit ALU with registered result and flags.
// Define SEQ_ALU_MUL_EN to build the iterative multiplier for op 8; otherwise op 8 is illegal.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             car,
    output logic             of,
    output logic             zf,
    output logic             nf,
    output logic             ill
);

    alu_state_e       r_state, w_state_next;
    logic             w_accept, w_is_mul, w_mul_done;
    logic [WIDTH-1:0] r_res, w_res, w_b_eff;
    logic             r_car, r_of, r_zf, r_nf, r_ill;
    logic             w_car, w_of, w_ill, w_cin, w_load;
    logic [WIDTH:0]   w_sum;

    assign in_ready = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    assign w_accept = in_valid & in_ready;

`ifdef SEQ_ALU_MUL_EN
    logic               w_mul_busy;
    logic [2*WIDTH-1:0] w_product;

    assign w_is_mul = (op == OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_accept & w_is_mul & ~w_mul_busy),
        .i_a       (a),
        .i_b       (b),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );
`else
    assign w_is_mul   = 1'b0;
    assign w_mul_done = 1'b0;
`endif

    // SUB reuses the adder as a + ~b + 1, so carry=1 means no borrow.
    assign w_cin   = (op == OP_SUB);
    assign w_b_eff = w_cin ? ~b : b;
    assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};

    always_comb begin
        w_res = '0;
        w_car = 1'b0;
        w_of  = 1'b0;
        w_ill = 1'b0;
        if (r_state == BUSY) begin
`ifdef SEQ_ALU_MUL_EN
            w_res = w_product[WIDTH-1:0];
            w_of  = |w_product[2*WIDTH-1:WIDTH];
`endif
        end else begin
            case (op)
                OP_ADD, OP_SUB: begin
                    w_res = w_sum[WIDTH-1:0];
                    w_car = w_sum[WIDTH];
                    w_of  = (a[WIDTH-1] == w_b_eff[WIDTH-1]) & (w_sum[WIDTH-1] != a[WIDTH-1]);
                end
                OP_NOT:  w_res = ~a;
                OP_AND:  w_res = a & b;
                OP_OR:   w_res = a | b;
                OP_XOR:  w_res = a ^ b;
                OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                OP_EQ:   w_res = {{(WIDTH-1){1'b0}}, (a == b)};
                default: w_ill = 1'b1;
            endcase
        end
    end

    assign w_load = (w_accept & ~w_is_mul) | ((r_state == BUSY) & w_mul_done);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept)
                    w_state_next = w_is_mul ? BUSY : DONE;
                else if ((r_state == DONE) && out_ready)
                    w_state_next = IDLE;
            end
            BUSY: begin
                if (w_mul_done)
                    w_state_next = DONE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_res   <= '0;
            r_car   <= 1'b0;
            r_of    <= 1'b0;
            r_zf    <= 1'b0;
            r_nf    <= 1'b0;
            r_ill   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_res <= w_res;
                r_car <= w_car;
                r_of  <= w_of;
                r_zf  <= (w_res == '0);
                r_nf  <= w_res[WIDTH-1];
                r_ill <= w_ill;
            end
        end
    end

    assign out_valid = (r_state == DONE);
    assign res       = r_res;
    assign car       = r_car;
    assign of        = r_of;
    assign zf        = r_zf;
    assign nf        = r_nf;
    assign ill       = r_ill;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=4): directed table, MUL/backpressure/reset
// sequences, back-to-back throughput and randomized ops against an arithmetic model.
module tb_seq_alu;

    localparam int W = 4;
    localparam int M = 1 << W;
`ifdef SEQ_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] res;
    logic         car, of, zf, nf, ill;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .car(car), .of(of), .zf(zf), .nf(nf), .ill(ill)
    );

    typedef struct {
        int a; int b; int op;
        int res; int car; int of; int zf; int nf; int ill;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= M / 2) ? v - M : v;
    endfunction

    // Reference computed from the arithmetic definitions, not from the adder structure.
    function automatic vec_t model(input int va, input int vb, input int vop);
        vec_t e;
        int s;
        e = '{va, vb, vop, 0, 0, 0, 0, 0, 0};
        case (vop)
            0: begin
                s = va + vb; e.res = s % M; e.car = int'(s >= M);
                s = sgn(va) + sgn(vb); e.of = int'(s < -M / 2 || s > M / 2 - 1);
            end
            1: begin
                e.res = (va - vb + M) % M; e.car = int'(va >= vb);
                s = sgn(va) - sgn(vb); e.of = int'(s < -M / 2 || s > M / 2 - 1);
            end
            2: e.res = M - 1 - va;
            3: e.res = va & vb;
            4: e.res = va | vb;
            5: e.res = va ^ vb;
            6: e.res = int'(sgn(va) < sgn(vb));
            7: e.res = int'(va == vb);
            8: begin
                if (MUL_EN) begin
                    s = va * vb; e.res = s % M; e.of = int'(s >= M);
                end else e.ill = 1;
            end
            default: e.ill = 1;
        endcase
        e.zf = int'(e.res == 0);
        e.nf = int'(e.res >= M / 2);
        return e;
    endfunction

    function automatic logic [63:0] pk_exp(input vec_t e);
        return 64'((e.res << 5) | (e.car << 4) | (e.of << 3) | (e.zf << 2) | (e.nf << 1) | e.ill);
    endfunction

    function automatic logic [63:0] pk_dut();
        return 64'({res, car, of, zf, nf, ill});
    endfunction

    function automatic int exp_lat(input int vop);
        return (vop == 8 && MUL_EN) ? W + 1 : 1;
    endfunction

    // One complete transaction with out_ready held high; checks latency, busy stall and outputs.
    task automatic run_op(input string tag, input int va, input int vb, input int vop, input vec_t e);
        int n;
        int lat;
        @(negedge clk);
        a = W'(va); b = W'(vb); op = 4'(vop); in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            if (lat == 1 && exp_lat(vop) > 1)
                chk({tag, "_busy_in_ready"}, 64'(in_ready), 64'd0);
        end while (!out_valid && lat < 40);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat(vop)));
        chk({tag, "_outputs"}, pk_dut(), pk_exp(e));
        $display("txn %s op=%0d a=%0h b=%0h res=%0h car=%0b of=%0b zf=%0b nf=%0b ill=%0b lat=%0d",
                 tag, vop, va, vb, res, car, of, zf, nf, ill, lat);
    endtask

    vec_t tbl[15];
    vec_t e;
    vec_t b2b[6];
    logic [63:0] held;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{7, 1, 0, 8, 0, 1, 0, 1, 0};
        tbl[1]  = '{5, 3, 1, 2, 1, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 1, 15, 0, 0, 0, 1, 0};
        tbl[3]  = '{15, 1, 6, 1, 0, 0, 0, 0, 0};
        tbl[4]  = '{5, 5, 7, 1, 0, 0, 0, 0, 0};
        tbl[5]  = '{5, 4, 7, 0, 0, 0, 1, 0, 0};
        tbl[6]  = '{5, 0, 2, 10, 0, 0, 0, 1, 0};
        tbl[7]  = '{12, 10, 3, 8, 0, 0, 0, 1, 0};
        tbl[8]  = '{12, 10, 4, 14, 0, 0, 0, 1, 0};
        tbl[9]  = '{12, 10, 5, 6, 0, 0, 0, 0, 0};
        tbl[10] = '{3, 4, 9, 0, 0, 0, 1, 0, 1};
        tbl[11] = '{3, 4, 15, 0, 0, 0, 1, 0, 1};
        tbl[12] = '{8, 8, 0, 0, 1, 1, 1, 0, 0};
        tbl[13] = '{8, 1, 1, 7, 1, 1, 0, 0, 0};
        tbl[14] = '{1, 1, 6, 0, 0, 0, 1, 0, 0};

        // Reset state.
        #12;
        chk("reset_outputs", pk_dut(), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 15; i++)
            run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].op, tbl[i]);

        // MUL 6*3 = 18: low nibble 2, overflow set (or illegal without the multiplier).
        if (MUL_EN) e = '{6, 3, 8, 2, 0, 1, 0, 0, 0};
        else        e = '{6, 3, 8, 0, 0, 0, 1, 0, 1};
        run_op("mul_6x3", 6, 3, 8, e);
        run_op("mul_fxf", 15, 15, 8, model(15, 15, 8));

        // Backpressure: result held while out_ready=0, a pending request is ignored.
        @(negedge clk);
        a = 4'd2; b = 4'd3; op = 4'd0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        a = 4'd9; b = 4'd9; op = 4'd5;
        held = pk_dut();
        chk("bp_first_outputs", held, pk_exp(model(2, 3, 0)));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_valid_%0d", k), 64'(out_valid), 64'd1);
            chk($sformatf("bp_stable_%0d", k), pk_dut(), held);
            chk($sformatf("bp_in_ready_%0d", k), 64'(in_ready), 64'd0);
        end
        a = 4'd1; b = 4'd1; op = 4'd0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_release_valid", 64'(out_valid), 64'd1);
        chk("bp_release_outputs", pk_dut(), pk_exp(model(1, 1, 0)));
        @(negedge clk);
        chk("bp_drain_valid", 64'(out_valid), 64'd0);
        $display("txn backpressure res=%0h", res);

        // Back-to-back non-MUL ops: one result per cycle with out_ready high.
        for (int k = 0; k < 6; k++) begin
            int vop;
            vop = int'($urandom_range(0, 14));
            if (vop >= 8) vop++;
            b2b[k] = model(int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)), vop);
        end
        a = W'(b2b[0].a); b = W'(b2b[0].b); op = 4'(b2b[0].op); in_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_valid_%0d", k), 64'(out_valid), 64'd1);
            chk($sformatf("b2b_outputs_%0d", k), pk_dut(), pk_exp(b2b[k-1]));
            $display("txn b2b%0d op=%0d a=%0h b=%0h res=%0h", k - 1, b2b[k-1].op, b2b[k-1].a, b2b[k-1].b, res);
            if (k < 6) begin
                a = W'(b2b[k].a); b = W'(b2b[k].b); op = 4'(b2b[k].op);
            end else in_valid = 1'b0;
        end

        // Randomized ops, including MUL and illegal codes.
        for (int k = 0; k < 60; k++) begin
            int va, vb, vop;
            va = int'($urandom_range(0, M - 1));
            vb = int'($urandom_range(0, M - 1));
            vop = int'($urandom_range(0, 15));
            run_op($sformatf("rnd%0d", k), va, vb, vop, model(va, vb, vop));
        end

        // Reset two cycles into a MUL aborts it and clears every output.
        run_op("pre_reset", 9, 6, 3, model(9, 6, 3));
        @(negedge clk);
        a = 4'd6; b = 4'd3; op = 4'd8; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midmul_reset_outputs", pk_dut(), 64'd0);
        chk("midmul_reset_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midmul_release_in_ready", 64'(in_ready), 64'd1);
        run_op("after_reset_add", 3, 4, 0, '{3, 4, 0, 7, 0, 0, 0, 0, 0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
